// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the sequence counter datapath.
//   mode_e    - sequence select encoding carried on the 2-bit mode port
//   bin2gray  - binary to reflected Gray code (CODE_W bits, zero-extend narrower values)
//   gray2bin  - reflected Gray code to binary (CODE_W bits, zero-extend narrower values)
package counter_pkg;

    localparam int unsigned CODE_W = 32;

    typedef enum logic [1:0] {
        MODE_BIN_UP   = 2'b00,
        MODE_BIN_DOWN = 2'b01,
        MODE_GRAY     = 2'b10,
        MODE_JOHNSON  = 2'b11
    } mode_e;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin[CODE_W-1] = gray[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/counter_next_state.sv
// counter_next_state: combinational next-state and terminal-state decode.
//   count         in  WIDTH  current registered count
//   mode          in  2      sequence select (counter_pkg::mode_e)
//   next          out WIDTH  value the count takes on an enabled step
//   is_terminal   out 1      count matches the terminal pattern of the mode
//   johnson_legal out 1      count is a valid Johnson code (<= 1 adjacent-bit transition)
module counter_next_state
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next,
    output logic             is_terminal,
    output logic             johnson_legal
);

    // Binary compares are done one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT      = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   MOD_LAST_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MOD_LAST     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY     = ONE << (WIDTH - 1);
    localparam logic [WIDTH-2:0] T_ONE        = (WIDTH - 1)'(1);

    logic [WIDTH:0]   count_ext;
    logic [WIDTH-2:0] transitions;
    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] gray_bin_inc;
    logic [WIDTH-1:0] gray_next;

    assign count_ext = {1'b0, count};

    // One bit per adjacent pair that differs; legal when at most one is set.
    assign transitions   = count[WIDTH-1:1] ^ count[WIDTH-2:0];
    assign johnson_legal = (transitions & (transitions - T_ONE)) == '0;

    // Increment in the binary domain truncated to WIDTH so the wrap is mod 2**WIDTH.
    assign gray_bin     = WIDTH'(gray2bin(CODE_W'(count)));
    assign gray_bin_inc = gray_bin + ONE;
    assign gray_next    = WIDTH'(bin2gray(CODE_W'(gray_bin_inc)));

    always_comb begin
        next        = count;
        is_terminal = 1'b0;
        unique case (mode_e'(mode))
            MODE_BIN_UP: begin
                next        = (count_ext >= MOD_LAST_EXT) ? '0 : count + ONE;
                is_terminal = (count == MOD_LAST);
            end
            MODE_BIN_DOWN: begin
                next        = (count == '0 || count_ext >= MOD_EXT) ? MOD_LAST : count - ONE;
                is_terminal = (count == '0);
            end
            MODE_GRAY: begin
                next        = gray_next;
                is_terminal = (count == MSB_ONLY);
            end
            MODE_JOHNSON: begin
                next        = johnson_legal ? {count[WIDTH-2:0], ~count[WIDTH-1]} : '0;
                is_terminal = (count == MSB_ONLY);
            end
        endcase
    end

endmodule

// File: rtl/seq_counter.sv
// seq_counter: parametrised, mode-selectable sequence counter.
//   clk         in  1      system clock, rising edge
//   reset       in  1      asynchronous active-high reset
//   en          in  1      advance one step per clock
//   mode        in  2      00 bin up, 01 bin down, 10 Gray up, 11 Johnson
//   load        in  1      synchronous parallel load (beats en)
//   load_value  in  WIDTH  value written by load
//   count       out WIDTH  registered current state
//   tc          out 1      combinational terminal-state flag
//   wrap        out 1      registered pulse after a terminal-to-start step
module seq_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(4'b1100),
    parameter int unsigned      MODULUS     = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] next;
    logic             is_terminal;
    logic             johnson_legal;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_state (
        .count         (count),
        .mode          (mode),
        .next          (next),
        .is_terminal   (is_terminal),
        .johnson_legal (johnson_legal)
    );

    // A Johnson terminal only counts when the code is legal; illegal codes self-correct silently.
    assign tc = is_terminal & (johnson_legal | (mode_e'(mode) != MODE_JOHNSON));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RESET_VALUE;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= next;
            wrap  <= tc;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_counter.sv
module tb_seq_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'b0000;
    logic [3:0] count;
    logic       tc;
    logic       wrap;

    int checks = 0;
    int failures = 0;

    seq_counter #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1100),
        .MODULUS     (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tc         (tc),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if (count !== 4'b1100 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_initial: count=%b wrap=%b expected count=1100 wrap=0",
                     count, wrap);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 4'b1100 || wrap !== 1'b0 || tc !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold_%0d: count=%b wrap=%b tc=%b expected 1100/0/0",
                         i, count, wrap, tc);
            end
        end
        load = 1'b1;
        load_value = 4'b0011;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 4'b0011) begin
            failures++;
            $display("FAIL reset_preload: count=%b expected 0011", count);
        end
        // Assert reset between edges; must act before the next edge.
        #3 reset = 1'b1;
        #1;
        checks++;
        if (count !== 4'b1100 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_mid: count=%b wrap=%b expected count=1100 wrap=0",
                     count, wrap);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_bin_up();
        logic [3:0] exp_cnt [11];
        logic       exp_wrap [11];
        exp_cnt  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        exp_wrap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        mode = 2'b00;
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            checks++;
            if (count !== exp_cnt[i] || wrap !== exp_wrap[i]
                || tc !== (exp_cnt[i] == 4'd9)) begin
                failures++;
                $display("FAIL bin_up_step_%0d: count=%b wrap=%b tc=%b expected %b/%b/%b",
                         i, count, wrap, tc, exp_cnt[i], exp_wrap[i], exp_cnt[i] == 4'd9);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (count !== 4'd0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL bin_up_disable: count=%b wrap=%b expected 0000/0", count, wrap);
        end
    endtask

    task automatic test_bin_down();
        logic [3:0] exp_cnt [5];
        logic       exp_wrap [5];
        logic       exp_tc [5];
        exp_cnt  = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        exp_wrap = '{0, 0, 0, 1, 0};
        exp_tc   = '{0, 0, 1, 0, 0};
        mode = 2'b01;
        en = 1'b1;
        load = 1'b1;
        load_value = 4'b0011;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 4'b0011 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL bin_down_load: count=%b wrap=%b expected 0011/0", count, wrap);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count !== exp_cnt[i] || wrap !== exp_wrap[i] || tc !== exp_tc[i]) begin
                failures++;
                $display("FAIL bin_down_step_%0d: count=%b wrap=%b tc=%b expected %b/%b/%b",
                         i, count, wrap, tc, exp_cnt[i], exp_wrap[i], exp_tc[i]);
            end
        end
        load = 1'b1;
        load_value = 4'b1111;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (count !== 4'b1001 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL bin_down_out_of_range: count=%b wrap=%b expected 1001/0", count, wrap);
        end
    endtask

    task automatic test_gray();
        logic [3:0] seq [16];
        logic [3:0] prev;
        seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        mode = 2'b10;
        en = 1'b1;
        load = 1'b1;
        load_value = 4'b0000;
        tick();
        load = 1'b0;
        prev = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (count !== seq[i] || wrap !== (i == 15) || tc !== (seq[i] == 4'b1000)
                || $countones(count ^ prev) != 1) begin
                failures++;
                $display("FAIL gray_step_%0d: count=%b wrap=%b tc=%b prev=%b expected %b/%b/%b",
                         i, count, wrap, tc, prev, seq[i], i == 15, seq[i] == 4'b1000);
            end
            prev = count;
        end
    endtask

    task automatic test_johnson();
        logic [3:0] seq [8];
        seq = '{4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
        en = 1'b0;
        mode = 2'b11;
        #3 reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (count !== 4'b1100 || tc !== 1'b0) begin
            failures++;
            $display("FAIL johnson_start: count=%b tc=%b expected 1100/0", count, tc);
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count !== seq[i] || wrap !== (i == 1) || tc !== (seq[i] == 4'b1000)) begin
                failures++;
                $display("FAIL johnson_step_%0d: count=%b wrap=%b tc=%b expected %b/%b/%b",
                         i, count, wrap, tc, seq[i], i == 1, seq[i] == 4'b1000);
            end
        end
        load = 1'b1;
        load_value = 4'b0101;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (count !== 4'b0000 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL johnson_illegal: count=%b wrap=%b expected 0000/0", count, wrap);
        end
    endtask

    task automatic test_priority();
        mode = 2'b00;
        en = 1'b0;
        load = 1'b1;
        load_value = 4'b1001;
        tick();
        // Count sits at the terminal state; load must win over the wrapping step.
        en = 1'b1;
        load_value = 4'b0111;
        tick();
        checks++;
        if (count !== 4'b0111 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL prio_load_over_en: count=%b wrap=%b expected 0111/0", count, wrap);
        end
        load_value = 4'b0011;
        reset = 1'b1;
        tick();
        checks++;
        if (count !== 4'b1100 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL prio_reset_over_load: count=%b wrap=%b expected 1100/0", count, wrap);
        end
        reset = 1'b0;
        load_value = 4'b0100;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (count !== 4'b0101) begin
            failures++;
            $display("FAIL prio_up_step: count=%b expected 0101", count);
        end
        mode = 2'b01;
        tick();
        checks++;
        if (count !== 4'b0100) begin
            failures++;
            $display("FAIL prio_mode_switch: count=%b expected 0100", count);
        end
        // Reset during the wrap-pulse cycle clears both registers.
        mode = 2'b00;
        load = 1'b1;
        load_value = 4'b1001;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (count !== 4'b0000 || wrap !== 1'b1) begin
            failures++;
            $display("FAIL prio_wrap_setup: count=%b wrap=%b expected 0000/1", count, wrap);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (count !== 4'b1100 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL prio_reset_in_wrap: count=%b wrap=%b expected 1100/0", count, wrap);
        end
        tick();
        reset = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bin_up();
        test_bin_down();
        test_gray();
        test_johnson();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
